// File: rtl/gelu_cube_root_calculator_pkg.sv
// Shared widths and state encoding for the fixed-point cube-root calculator.
package gelu_pkg;
    localparam int DATA_WIDTH_DEF = 24;
    localparam int FRAC_BITS_DEF  = 16;
    localparam int ROOT_W         = 19;
    localparam int N_W            = 56;
    localparam int IDX_W          = 5;
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(ROOT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQR  = 2'd1,
        ST_CUB  = 2'd2,
        ST_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/gelu_cube_root_calculator.sv
// Signed fixed-point cube root by bitwise restoring search, one root bit per
// SQR/CUB cycle pair; result truncated toward zero.
module gelu_cube_root_calculator
    import gelu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  exact
);
    localparam int SQ_W  = 2 * ROOT_W;
    localparam int CUB_W = 3 * ROOT_W;

    state_e                r_state;
    logic                  r_sign;
    logic [N_W-1:0]        r_n;
    logic [ROOT_W-1:0]     r_y;
    logic [IDX_W-1:0]      r_idx;
    logic [SQ_W-1:0]       r_sq;
    logic [CUB_W-1:0]      r_cube;
    logic [DATA_WIDTH-1:0] r_y_out;
    logic                  r_valid_out;
    logic                  r_exact;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_mag;
    logic [N_W-1:0]        w_n;
    logic [ROOT_W-1:0]     w_t;
    logic [SQ_W-1:0]       w_sq;
    logic [CUB_W-1:0]      w_cube;
    logic                  w_take;
    logic [ROOT_W-1:0]     w_y_next;
    logic [CUB_W-1:0]      w_cube_next;
    logic [DATA_WIDTH-1:0] w_y_ext;

    assign ready_in  = (r_state == ST_IDLE);
    assign w_accept  = valid_in && ready_in;

    // Two's-complement negate keeps the most negative operand as 2^(W-1) unsigned.
    assign w_mag     = x_in[DATA_WIDTH-1] ? (~x_in + 1'b1) : x_in;
    assign w_n       = N_W'(w_mag) << (2 * FRAC_BITS);

    assign w_t       = r_y | (ROOT_W'(1) << r_idx);
    assign w_sq      = SQ_W'(w_t) * SQ_W'(w_t);
    assign w_cube    = CUB_W'(w_t) * CUB_W'(r_sq);
    assign w_take    = (w_cube <= CUB_W'(r_n));

    // The final bit decision and the registered result share the CUB->DONE edge.
    assign w_y_next    = w_take ? w_t : r_y;
    assign w_cube_next = w_take ? w_cube : r_cube;
    assign w_y_ext     = DATA_WIDTH'(w_y_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sign      <= 1'b0;
            r_n         <= '0;
            r_y         <= '0;
            r_idx       <= '0;
            r_sq        <= '0;
            r_cube      <= '0;
            r_y_out     <= '0;
            r_valid_out <= 1'b0;
            r_exact     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign  <= x_in[DATA_WIDTH-1];
                        r_n     <= w_n;
                        r_y     <= '0;
                        r_cube  <= '0;
                        r_idx   <= IDX_START;
                        r_state <= ST_SQR;
                    end
                end
                ST_SQR: begin
                    r_sq    <= w_sq;
                    r_state <= ST_CUB;
                end
                ST_CUB: begin
                    r_y    <= w_y_next;
                    r_cube <= w_cube_next;
                    if (r_idx == '0) begin
                        r_y_out     <= r_sign ? (-w_y_ext) : w_y_ext;
                        r_exact     <= (w_cube_next == CUB_W'(r_n));
                        r_valid_out <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_state <= ST_SQR;
                    end
                end
                ST_DONE: begin
                    if (ready_out) begin
                        r_valid_out <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign y_out     = r_y_out;
    assign valid_out = r_valid_out;
    assign exact     = r_exact;
endmodule

// File: doc/gelu_cube_root_calculator.md
GELU_CUBE_ROOT_CALCULATOR -- requirements
Module: gelu_cube_root_calculator

Interface
REQ-001 Parameter DATA_WIDTH, default 24, SHALL set the signed two's-complement data width.
REQ-002 Parameter FRAC_BITS, default 16, SHALL set the fractional bits (Q8.16 at defaults); only the defaults are verified.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 x_in  input  DATA_WIDTH  SHALL be the signed fixed-point operand.
REQ-006 valid_in  input  1  SHALL qualify x_in.
REQ-007 ready_in  output  1  SHALL be high only when a new operand can be accepted.
REQ-008 y_out  output  DATA_WIDTH  SHALL be the signed fixed-point cube root of x_in.
REQ-009 valid_out  output  1  SHALL qualify y_out and exact.
REQ-010 ready_out  input  1  SHALL be high when the downstream stage takes the result.
REQ-011 exact  output  1  SHALL be high when the returned root cubed equals the operand exactly.

Function
REQ-012 The block SHALL take an operand on a rising edge with valid_in and ready_in both high; ready_in SHALL equal (state == IDLE).
REQ-013 States SHALL be IDLE, SQR, CUB and DONE; transitions: IDLE->SQR on accept; SQR->CUB always; CUB->SQR while bit index > 0; CUB->DONE at bit index 0; DONE->IDLE on ready_out.
REQ-014 On accept, the block SHALL register sign = x_in[MSB], the magnitude |X| as a 24-bit unsigned value (0x800000 maps to 2^23), N = |X| << (2*FRAC_BITS) at 56 bits, root Y = 0 and bit index = 18.
REQ-015 In SQR, the block SHALL register sq = T*T, where T = Y | (1 << index) (19 bits, sq 38 bits).
REQ-016 In CUB, the block SHALL compute T*sq (57 bits) and set Y = T when T*sq <= N; it SHALL then decrement the index.
REQ-017 On the CUB->DONE edge, the block SHALL register y_out = sign ? -Y : Y (truncated toward zero), exact = (Y^3 == N), and valid_out = 1.
REQ-018 Latency SHALL be exactly 38 cycles: valid_out rises on the 38th rising edge after the accept edge.
REQ-019 valid_out, y_out and exact SHALL stay stable in DONE until a rising edge with ready_out high; valid_out SHALL be 0 after that edge.
REQ-020 ready_in SHALL be low in DONE, so no accept can coincide with a result handshake; the earliest next accept is the cycle after DONE->IDLE.
REQ-021 Zero input SHALL return y_out = 0 with exact = 1; the sign SHALL never give -0.
REQ-022 No overflow is possible: |Y| SHALL be <= 330280 for all inputs.
REQ-023 valid_in while ready_in is low SHALL be ignored, and x_in SHALL NOT be sampled.

Reset
REQ-024 While rst is high, the block SHALL set state = IDLE, ready_in = 1, valid_out = 0, y_out = 0, exact = 0 and clear all datapath registers, immediately and without a clock.
REQ-025 Reset mid-operation SHALL abandon the computation; no valid_out SHALL follow for that operand.

Structure
REQ-026 The shared package gelu_pkg SHALL hold DATA_WIDTH/FRAC_BITS defaults, ROOT_W = 19, N_W = 56 and the state enumeration.
REQ-027 The block SHALL be one module with no sub-module; its two multipliers (19x19, 19x38) SHALL be plain RTL operators.

Verification
REQ-028 Accept 0x080000 (8.0) -> after 38 cycles y_out = 0x020000, exact = 1.
REQ-029 Accept 0xFFE000 (-0.125) -> y_out = 0xFF8000 (-0.5), exact = 1. Accept 0x010000 -> y_out = 0x010000, exact = 1.
REQ-030 Accept 0x020000 (2.0) -> y_out = 0x01428A, exact = 0. Accept 0x800000 -> y_out = 0xFAF5D8, exact = 0. Accept 0x000000 -> y_out = 0x000000, exact = 1.
REQ-031 Backpressure: hold ready_out = 0 for 10 cycles after valid_out -> y_out stable, ready_in = 0, a valid_in pulse during DONE is ignored; ready_out = 1 -> valid_out = 0 and ready_in = 1 on the next cycle.
REQ-032 Assert rst at cycle 20 of a computation -> outputs clear at once, no valid_out follows; the next operand 0x080000 yields 0x020000.
REQ-033 Random sweep of 1000 operands against a reference model -> every y_out equals the truncated-toward-zero cube root, and the latency is exactly 38 cycles.
